// File: rtl/p5_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// p5_mem_ctrl_pkg
// Definitions shared by the P5 data-RAM port controller and its optional
// memory-mapped I/O register block.
//   state_e  : 2-bit controller FSM encoding (IDLE=0, ISSUE=1, CAPTURE=2, RESP=3)
//   LED_OFS  : I/O window offset of the LED register
//   SW_OFS   : I/O window offset of the switch input
// ---------------------------------------------------------------------------
package p5_mem_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_RESP    = 2'd3
   } state_e;

   localparam int LED_OFS = 0;
   localparam int SW_OFS  = 1;

endpackage

// File: rtl/p5_mem_ctrl_mmio_regs.sv
// ---------------------------------------------------------------------------
// p5_mmio_regs
// Small I/O register block behind the P5 memory-mapped window. Only
// instantiated by p5_mem_ctrl when P5_MMIO_EN is defined.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   wr        : write strobe (already qualified as an I/O-window store)
//   addr_ofs  : address offset inside the window
//   wdata     : store data
//   io_sw     : switch inputs, read-only at SW_OFS
//   rd_data   : combinational read mux (old LED value while wr is high)
//   io_led    : LED register, read/write at LED_OFS
// ---------------------------------------------------------------------------
module p5_mmio_regs
   import p5_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr_ofs,
   input  logic [15:0]       wdata,
   input  logic [15:0]       io_sw,
   output logic [15:0]       rd_data,
   output logic [15:0]       io_led
);

   logic [15:0] led_q;
   logic [15:0] led_d;

   always_comb begin
      led_d = led_q;
      if (wr && (addr_ofs == ADDR_W'(LED_OFS))) begin
         led_d = wdata;
      end
   end

   // Read mux sees the register before the same-edge write lands, so a
   // store response carries the old LED value.
   always_comb begin
      rd_data = '0;
      if (addr_ofs == ADDR_W'(LED_OFS)) begin
         rd_data = led_q;
      end else if (addr_ofs == ADDR_W'(SW_OFS)) begin
         rd_data = io_sw;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led_q <= '0;
      end else begin
         led_q <= led_d;
      end
   end

   assign io_led = led_q;

endmodule

// File: rtl/p5_mem_ctrl.sv
// ---------------------------------------------------------------------------
// p5_mem_ctrl
// Initiator side of the P5 data-RAM port. Accepts one load/store at a time
// from the core (valid/ready), drives a synchronous RAM with a 1-cycle
// registered read (read-before-write), and returns exactly one response per
// request. A store response carries the pre-write word.
// Optional feature macro: P5_MMIO_EN -- decodes addresses >= MMIO_BASE to the
// p5_mmio_regs block (LED register, switch input) instead of the RAM.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   req_valid/req_ready/req_we/
//   req_addr/req_wdata                : core request channel
//   rsp_valid/rsp_ready/rsp_rdata     : core response channel
//   mem_address/mem_data_in/mem_we    : to RAM
//   mem_data_out                      : registered read data from RAM
//   io_sw, io_led                     : I/O pins (io_led tied 0 without MMIO)
// ---------------------------------------------------------------------------
module p5_mem_ctrl
   import p5_mem_ctrl_pkg::*;
#(
   parameter int                ADDR_W    = 8,
   parameter int                DATA_W    = 16,
   parameter logic [ADDR_W-1:0] MMIO_BASE = 8'hF0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_data_out,
   input  logic [15:0]       io_sw,
   output logic [15:0]       io_led
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              io_hit;
   logic [DATA_W-1:0] io_rd;
   logic              mmio_wr;

`ifdef P5_MMIO_EN
   assign io_hit = (addr_q >= MMIO_BASE);

   p5_mmio_regs #(
      .ADDR_W (ADDR_W)
   ) u_mmio (
      .clk      (clk),
      .rst      (rst),
      .wr       (mmio_wr),
      .addr_ofs (addr_q - MMIO_BASE),
      .wdata    (wdata_q),
      .io_sw    (io_sw),
      .rd_data  (io_rd),
      .io_led   (io_led)
   );
`else
   assign io_hit = 1'b0;
   assign io_rd  = '0;
   assign io_led = '0;

   // Sink for signals that only matter when the I/O window is built in.
   logic unused_io;
   assign unused_io = ^{io_sw, MMIO_BASE, mmio_wr};
`endif

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      rdata_d   = rdata_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_we    = 1'b0;
      mmio_wr   = 1'b0;

      case (state_q)
         S_IDLE: begin
            req_ready = ~rst;
            if (req_valid && !rst) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               we_d    = req_we;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // RAM reads old data and writes at the closing edge.
            mem_we  = we_q & ~rst & ~io_hit;
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            rdata_d = io_hit ? io_rd : mem_data_out;
            // I/O register write lands on the same edge the old value is
            // captured, mirroring the RAM's read-before-write behaviour.
            mmio_wr = we_q & io_hit & ~rst;
            state_d = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
      end
   end

   assign mem_address = addr_q;
   assign mem_data_in = wdata_q;
   assign rsp_rdata   = rdata_q;

endmodule

// File: tb/tb_p5_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_p5_mem_ctrl
// Pairs p5_mem_ctrl with a 256x16 synchronous RAM model (registered read,
// old data on write). Requests push their expected response into a queue;
// a monitor pops and compares on every response handshake.
// RAM is preloaded with ram[a] = 16'hC000 | a.
// ---------------------------------------------------------------------------
module tb_p5_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [7:0]  req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [15:0] rsp_rdata;
   logic [7:0]  mem_address;
   logic [15:0] mem_data_in;
   logic        mem_we;
   logic [15:0] mem_data_out;
   logic [15:0] io_sw = 16'h3C3C;
   logic [15:0] io_led;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int we_cnt = 0;
   logic [15:0] exp_q[$];
   logic [15:0] ram [256];

   p5_mem_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .mem_address  (mem_address),
      .mem_data_in  (mem_data_in),
      .mem_we       (mem_we),
      .mem_data_out (mem_data_out),
      .io_sw        (io_sw),
      .io_led       (io_led)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 16'hC000 | 16'(i);
   end

   always @(posedge clk) begin
      if (mem_we) ram[mem_address] <= mem_data_in;
      mem_data_out <= ram[mem_address];
      cyc <= cyc + 1;
   end

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
      end else begin
         $display("ok   %s = %h", nm, act);
      end
   endfunction

   // Monitor: samples just after the falling edge, where inputs and outputs
   // are settled for the upcoming rising edge.
   initial begin
      logic [15:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (mem_we) we_cnt++;
         if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL rsp_unexpected got=%h exp=none t=%0t", rsp_rdata, $time);
            end else begin
               e = exp_q.pop_front();
               chk("rsp", {16'h0, rsp_rdata}, {16'h0, e});
            end
         end
      end
   end

   // Issue one request; returns the cycle count just before the accepting
   // edge. Leaves time at the falling edge after that accept.
   task automatic do_req(input logic we, input logic [7:0] a, input logic [15:0] d,
                         input logic [15:0] exp, input bit push, output int acc);
      int n = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      #1;
      while (!req_ready && n < 30) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
      else if (push) exp_q.push_back(exp);
      acc = cyc;
      $display("req we=%0b addr=%h wdata=%h exp=%h", we, a, d, exp);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk("drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int a0, a1, w0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req_ready", {31'h0, req_ready}, 32'd0);
      chk("rst_mem_we", {31'h0, mem_we}, 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", {16'h0, rsp_rdata}, 32'd0);
      chk("rst_mem_address", {24'h0, mem_address}, 32'd0);
      chk("rst_io_led", {16'h0, io_led}, 32'd0);

      // 1: store then load, with latency checks
      do_req(1'b1, 8'h12, 16'hBEEF, 16'hC012, 1'b1, a0);
      @(negedge clk); #1;
      chk("t1_st_lat_k1", {31'h0, rsp_valid}, 32'd0);
      @(negedge clk); #1;
      chk("t1_st_lat_k2", {31'h0, rsp_valid}, 32'd1);
      do_req(1'b0, 8'h12, 16'h0000, 16'hBEEF, 1'b1, a0);
      @(negedge clk); #1;
      chk("t1_ld_lat_k1", {31'h0, rsp_valid}, 32'd0);
      @(negedge clk); #1;
      chk("t1_ld_lat_k2", {31'h0, rsp_valid}, 32'd1);
      drain();

      // 2: backpressure for several cycles in RESP
      rsp_ready = 1'b0;
      do_req(1'b0, 8'h12, 16'h0000, 16'hBEEF, 1'b1, a0);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h00;
      begin
         int n = 0;
         #1;
         while (!rsp_valid && n < 10) begin
            @(negedge clk); #1; n++;
         end
      end
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_valid", {31'h0, rsp_valid}, 32'd1);
         chk("t2_hold_rdata", {16'h0, rsp_rdata}, 32'h0000BEEF);
         chk("t2_hold_ready", {31'h0, req_ready}, 32'd0);
         @(negedge clk); #1;
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      req_valid = 1'b0;
      do_req(1'b0, 8'h00, 16'h0000, 16'hC000, 1'b1, a0);
      drain();

      // 3: back-to-back loads
      w0 = we_cnt;
      do_req(1'b0, 8'h00, 16'h0000, 16'hC000, 1'b1, a0);
      do_req(1'b0, 8'hFF, 16'h0000, 16'hC0FF, 1'b1, a1);
      chk("t3_accept_gap", 32'(a1 - a0), 32'd4);
      drain();
      chk("t3_no_mem_we", 32'(we_cnt - w0), 32'd0);

      // 4: reset during ISSUE of a store drops it
      w0 = we_cnt;
      do_req(1'b1, 8'h40, 16'h1234, 16'h0000, 1'b0, a0);
      rst = 1'b1;
      #1;
      chk("t4_mem_we_rst", {31'h0, mem_we}, 32'd0);
      chk("t4_req_ready_rst", {31'h0, req_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t4_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      chk("t4_mem_address", {24'h0, mem_address}, 32'd0);
      chk("t4_ram40", {16'h0, ram[8'h40]}, 32'h0000C040);
      chk("t4_no_mem_we", 32'(we_cnt - w0), 32'd0);
      do_req(1'b0, 8'h40, 16'h0000, 16'hC040, 1'b1, a0);
      drain();

`ifdef P5_MMIO_EN
      // 5: I/O window
      do_req(1'b1, 8'hF0, 16'h00A5, 16'h0000, 1'b1, a0);
      drain();
      chk("t5_io_led", {16'h0, io_led}, 32'h000000A5);
      chk("t5_ramF0", {16'h0, ram[8'hF0]}, 32'h0000C0F0);
      do_req(1'b0, 8'hF1, 16'h0000, 16'h3C3C, 1'b1, a0);
      do_req(1'b0, 8'hF7, 16'h0000, 16'h0000, 1'b1, a0);
      do_req(1'b1, 8'hF0, 16'h1111, 16'h00A5, 1'b1, a0);
      do_req(1'b1, 8'hF1, 16'h7777, 16'h3C3C, 1'b1, a0);
      drain();
      chk("t5_io_led2", {16'h0, io_led}, 32'h00001111);
      chk("t5_ramF1", {16'h0, ram[8'hF1]}, 32'h0000C0F1);
`else
      // 6: no I/O window, everything goes to RAM
      do_req(1'b1, 8'hF0, 16'h00A5, 16'hC0F0, 1'b1, a0);
      drain();
      chk("t6_ramF0", {16'h0, ram[8'hF0]}, 32'h000000A5);
      chk("t6_io_led", {16'h0, io_led}, 32'd0);
      do_req(1'b0, 8'hF0, 16'h0000, 16'h00A5, 1'b1, a0);
      do_req(1'b1, 8'hFF, 16'h5555, 16'hC0FF, 1'b1, a0);
      do_req(1'b0, 8'hFF, 16'h0000, 16'h5555, 1'b1, a0);
      drain();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
